// File: rtl/register_file_16_pkg.sv
// Shared definitions for the crp16 general-purpose register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding on read ports).
package register_file_16_pkg;

    localparam int REG_COUNT     = 16;
    localparam int REG_ADDR_BITS = 4;
    // Every register bit resets to this value.
    localparam logic RESET_BIT   = 1'b0;

    // One-hot mask selecting a single register index in the pending scoreboard.
    function automatic logic [REG_COUNT-1:0] index_mask(input logic [REG_ADDR_BITS-1:0] idx);
        logic [REG_COUNT-1:0] one_s;
        one_s = {{(REG_COUNT-1){1'b0}}, 1'b1};
        index_mask = one_s << idx;
    endfunction

endpackage

// File: rtl/register_file_16_mux.sv
// 16-to-1 operand selection mux, one instance per register file read port.
module mux_16_to_1 #(
    parameter int bits = 16
) (
    input  logic [3:0]      select,
    input  logic [bits-1:0] a,
    input  logic [bits-1:0] b,
    input  logic [bits-1:0] c,
    input  logic [bits-1:0] d,
    input  logic [bits-1:0] e,
    input  logic [bits-1:0] f,
    input  logic [bits-1:0] g,
    input  logic [bits-1:0] h,
    input  logic [bits-1:0] i,
    input  logic [bits-1:0] j,
    input  logic [bits-1:0] k,
    input  logic [bits-1:0] l,
    input  logic [bits-1:0] m,
    input  logic [bits-1:0] n,
    input  logic [bits-1:0] o,
    input  logic [bits-1:0] p,
    output logic [bits-1:0] y
);

    // Select one of the sixteen inputs by index.
    always_comb begin
        y = {bits{1'b0}};
        case (select)
            4'd0:    y = a;
            4'd1:    y = b;
            4'd2:    y = c;
            4'd3:    y = d;
            4'd4:    y = e;
            4'd5:    y = f;
            4'd6:    y = g;
            4'd7:    y = h;
            4'd8:    y = i;
            4'd9:    y = j;
            4'd10:   y = k;
            4'd11:   y = l;
            4'd12:   y = m;
            4'd13:   y = n;
            4'd14:   y = o;
            4'd15:   y = p;
            default: y = {bits{1'b0}};
        endcase
    end

endmodule

// File: rtl/register_file_16.sv
// crp16 register file: 16 registers, one synchronous write port, two
// combinational read ports and a per-register pending-write scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN forwards write_data to a read
// port addressing write_addr in the same cycle.
module register_file_16
    import register_file_16_pkg::*;
#(
    parameter int bits = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write_en,
    input  logic [REG_ADDR_BITS-1:0] write_addr,
    input  logic [bits-1:0]          write_data,
    input  logic                     lock_en,
    input  logic [REG_ADDR_BITS-1:0] lock_addr,
    input  logic [REG_ADDR_BITS-1:0] read_addr_a,
    input  logic [REG_ADDR_BITS-1:0] read_addr_b,
    output logic [bits-1:0]          read_data_a,
    output logic [bits-1:0]          read_data_b,
    output logic                     busy_a,
    output logic                     busy_b
);

    logic [bits-1:0]      regs_r [REG_COUNT];
    logic [REG_COUNT-1:0] pending_r;
    logic [REG_COUNT-1:0] pending_next_s;
    logic [bits-1:0]      mux_a_s;
    logic [bits-1:0]      mux_b_s;

    // Scoreboard update: a write clears its entry, a lock sets its entry;
    // applying the set last lets a new producer win over a same-index write.
    always_comb begin
        pending_next_s = pending_r;
        if (write_en) begin
            pending_next_s = pending_next_s & ~index_mask(write_addr);
        end else begin
            pending_next_s = pending_next_s;
        end
        if (lock_en) begin
            pending_next_s = pending_next_s | index_mask(lock_addr);
        end else begin
            pending_next_s = pending_next_s;
        end
    end

    // Register storage and scoreboard state; reset discards writes and locks.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int idx = 0; idx < REG_COUNT; idx++) begin
                regs_r[idx] <= {bits{RESET_BIT}};
            end
            pending_r <= {REG_COUNT{RESET_BIT}};
        end else begin
            if (write_en) begin
                regs_r[write_addr] <= write_data;
            end
            pending_r <= pending_next_s;
        end
    end

    mux_16_to_1 #(.bits(bits)) u_mux_a (
        .select (read_addr_a),
        .a (regs_r[0]),  .b (regs_r[1]),  .c (regs_r[2]),  .d (regs_r[3]),
        .e (regs_r[4]),  .f (regs_r[5]),  .g (regs_r[6]),  .h (regs_r[7]),
        .i (regs_r[8]),  .j (regs_r[9]),  .k (regs_r[10]), .l (regs_r[11]),
        .m (regs_r[12]), .n (regs_r[13]), .o (regs_r[14]), .p (regs_r[15]),
        .y (mux_a_s)
    );

    mux_16_to_1 #(.bits(bits)) u_mux_b (
        .select (read_addr_b),
        .a (regs_r[0]),  .b (regs_r[1]),  .c (regs_r[2]),  .d (regs_r[3]),
        .e (regs_r[4]),  .f (regs_r[5]),  .g (regs_r[6]),  .h (regs_r[7]),
        .i (regs_r[8]),  .j (regs_r[9]),  .k (regs_r[10]), .l (regs_r[11]),
        .m (regs_r[12]), .n (regs_r[13]), .o (regs_r[14]), .p (regs_r[15]),
        .y (mux_b_s)
    );

`ifdef REGFILE_BYPASS_EN
    logic hit_a_s;
    logic hit_b_s;

    // Forward the in-flight write to a port reading its destination; such a
    // port reports not busy unless a new lock lands on the same index.
    always_comb begin
        hit_a_s     = write_en && (read_addr_a == write_addr);
        hit_b_s     = write_en && (read_addr_b == write_addr);
        read_data_a = mux_a_s;
        read_data_b = mux_b_s;
        busy_a      = pending_r[read_addr_a];
        busy_b      = pending_r[read_addr_b];
        if (hit_a_s) begin
            read_data_a = write_data;
            busy_a      = lock_en && (lock_addr == read_addr_a);
        end else begin
            read_data_a = mux_a_s;
        end
        if (hit_b_s) begin
            read_data_b = write_data;
            busy_b      = lock_en && (lock_addr == read_addr_b);
        end else begin
            read_data_b = mux_b_s;
        end
    end
`else
    // Read ports return stored state only.
    always_comb begin
        read_data_a = mux_a_s;
        read_data_b = mux_b_s;
        busy_a      = pending_r[read_addr_a];
        busy_b      = pending_r[read_addr_b];
    end
`endif

endmodule

// File: tb/tb_register_file_16.sv
// Self-checking bench for register_file_16 with a behavioural array model.
module tb_register_file_16;

    logic        clock = 1'b0;
    logic        reset;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [15:0] write_data;
    logic        lock_en;
    logic [3:0]  lock_addr;
    logic [3:0]  read_addr_a;
    logic [3:0]  read_addr_b;
    logic [15:0] read_data_a;
    logic [15:0] read_data_b;
    logic        busy_a;
    logic        busy_b;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: plain arrays of register values and pending flags.
    logic [15:0] m_reg  [16];
    bit          m_pend [16];

    register_file_16 #(.bits(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .lock_en     (lock_en),
        .lock_addr   (lock_addr),
        .read_addr_a (read_addr_a),
        .read_addr_b (read_addr_b),
        .read_data_a (read_data_a),
        .read_data_b (read_data_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] exp_data(input logic [3:0] addr);
`ifdef REGFILE_BYPASS_EN
        if (write_en && addr == write_addr) return write_data;
`endif
        return m_reg[addr];
    endfunction

    function automatic logic exp_busy(input logic [3:0] addr);
`ifdef REGFILE_BYPASS_EN
        if (write_en && addr == write_addr) return lock_en && (lock_addr == addr);
`endif
        return m_pend[addr];
    endfunction

    // Advance one clock edge, applying the architectural rules to the model.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            for (int r = 0; r < 16; r++) begin
                m_reg[r]  = 16'h0000;
                m_pend[r] = 1'b0;
            end
        end else begin
            if (write_en) begin
                m_reg[write_addr]  = write_data;
                m_pend[write_addr] = 1'b0;
            end
            if (lock_en) m_pend[lock_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; write_en = 1'b0; lock_en = 1'b0;
        write_addr = 4'd0; write_data = 16'h0000; lock_addr = 4'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        write_en = 1'b1; write_data = 16'hFFFF; lock_en = 1'b1;
        reset = 1'b1;
        tick();
        idle_inputs();
        for (int r = 0; r < 16; r++) begin
            read_addr_a = 4'(r); read_addr_b = 4'(15 - r);
            #1;
            vectors++;
            if (read_data_a !== 16'h0000 || read_data_b !== 16'h0000 ||
                busy_a !== 1'b0 || busy_b !== 1'b0) begin
                miscompares++;
                $display("FAIL reset idx %0d: got a=%h b=%h ba=%b bb=%b, want all zero",
                         r, read_data_a, read_data_b, busy_a, busy_b);
            end
        end
    endtask

    task automatic test_write_all();
        for (int r = 0; r < 16; r++) begin
            write_en = 1'b1; write_addr = 4'(r); write_data = 16'h1000 + 16'(r);
            tick();
        end
        idle_inputs();
        for (int r = 0; r < 16; r++) begin
            read_addr_a = 4'(r); read_addr_b = 4'(15 - r);
            #1;
            vectors++;
            if (read_data_a !== 16'h1000 + 16'(r) || read_data_b !== 16'h100F - 16'(r)) begin
                miscompares++;
                $display("FAIL write_all idx %0d: got a=%h b=%h, want a=%h b=%h", r,
                         read_data_a, read_data_b, 16'h1000 + 16'(r), 16'h100F - 16'(r));
            end
        end
    endtask

    task automatic test_read_during_write();
        logic [15:0] want_s;
        read_addr_a = 4'd5;
        write_en = 1'b1; write_addr = 4'd5; write_data = 16'hBEEF;
        #1;
`ifdef REGFILE_BYPASS_EN
        want_s = 16'hBEEF;
`else
        want_s = 16'h1005;
`endif
        vectors++;
        if (read_data_a !== want_s) begin
            miscompares++;
            $display("FAIL rdw_same_cycle: got %h want %h", read_data_a, want_s);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (read_data_a !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL rdw_next_cycle: got %h want beef", read_data_a);
        end
    endtask

    task automatic test_lock_write();
        lock_en = 1'b1; lock_addr = 4'd3;
        tick();
        idle_inputs();
        read_addr_a = 4'd3;
        #1;
        vectors++;
        if (busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_busy: got %b want 1", busy_a);
        end
        write_en = 1'b1; write_addr = 4'd3; write_data = 16'h0042;
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (busy_a !== 1'b0 || read_data_a !== 16'h0042) begin
            miscompares++;
            $display("FAIL write_clears: got busy=%b data=%h want busy=0 data=0042",
                     busy_a, read_data_a);
        end
    endtask

    task automatic test_same_edge();
        lock_en = 1'b1; lock_addr = 4'd7;
        write_en = 1'b1; write_addr = 4'd7; write_data = 16'h1234;
        tick();
        idle_inputs();
        read_addr_a = 4'd7;
        #1;
        vectors++;
        if (read_data_a !== 16'h1234 || busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL same_index: got data=%h busy=%b want 1234/1", read_data_a, busy_a);
        end
        lock_en = 1'b1; lock_addr = 4'd2;
        write_en = 1'b1; write_addr = 4'd9; write_data = 16'h0909;
        tick();
        idle_inputs();
        read_addr_a = 4'd2; read_addr_b = 4'd9;
        #1;
        vectors++;
        if (busy_a !== 1'b1 || busy_b !== 1'b0 || read_data_b !== 16'h0909) begin
            miscompares++;
            $display("FAIL diff_index: got ba=%b bb=%b db=%h want 1/0/0909",
                     busy_a, busy_b, read_data_b);
        end
    endtask

    task automatic test_reset_mid();
        lock_en = 1'b1; lock_addr = 4'd1;
        tick();
        lock_addr = 4'd4;
        tick();
        idle_inputs();
        write_en = 1'b1; write_addr = 4'd4; write_data = 16'hAAAA;
        tick();
        write_addr = 4'd1; write_data = 16'h5555; lock_en = 1'b1; lock_addr = 4'd1;
        reset = 1'b1;
        tick();
        idle_inputs();
        for (int r = 0; r < 16; r++) begin
            read_addr_a = 4'(r); read_addr_b = 4'(r);
            #1;
            vectors++;
            if (read_data_a !== 16'h0000 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid idx %0d: got data=%h ba=%b bb=%b want 0/0/0",
                         r, read_data_a, busy_a, busy_b);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset       = ($urandom_range(0, 49) == 0);
            write_en    = $urandom_range(0, 1) == 1;
            write_addr  = 4'($urandom_range(0, 15));
            write_data  = 16'($urandom);
            lock_en     = $urandom_range(0, 2) == 0;
            lock_addr   = 4'($urandom_range(0, 15));
            read_addr_a = ($urandom_range(0, 3) == 0) ? write_addr : 4'($urandom_range(0, 15));
            read_addr_b = ($urandom_range(0, 3) == 0) ? lock_addr  : 4'($urandom_range(0, 15));
            #1;
            vectors++;
            if (read_data_a !== exp_data(read_addr_a) || read_data_b !== exp_data(read_addr_b) ||
                busy_a !== exp_busy(read_addr_a) || busy_b !== exp_busy(read_addr_b)) begin
                miscompares++;
                $display("FAIL random cycle %0d: got a=%h b=%h ba=%b bb=%b want a=%h b=%h ba=%b bb=%b",
                         c, read_data_a, read_data_b, busy_a, busy_b,
                         exp_data(read_addr_a), exp_data(read_addr_b),
                         exp_busy(read_addr_a), exp_busy(read_addr_b));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            m_reg[r] = 16'h0000; m_pend[r] = 1'b0;
        end
        idle_inputs();
        read_addr_a = 4'd0; read_addr_b = 4'd0;
        #1;
        test_reset();
        test_write_all();
        test_read_during_write();
        test_lock_write();
        test_same_edge();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
